lot_checker_n: RTL



---
 rtl/lot_checker_n.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/lot_checker_n.sv
// Parametrised lottery ticket checker: grades NDIG BCD digits against a loadable
// winning number by the longest run of consecutive matching positions.
module lot_checker_n #(
  parameter int                  NDIG    = 5,
  parameter logic [4*NDIG-1:0]   WIN_DEF = 20'h47019,
  parameter int                  RUN2    = 3,
  parameter int                  CNT_W   = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fim_jogo,
  input  logic                          carrega,
  input  logic [4*NDIG-1:0]             win_in,
  input  logic                          insere,
  input  logic [3:0]                    num,
  input  logic                          fim,
  output logic [1:0]                    premio,
  output logic [CNT_W-1:0]              p1,
  output logic [CNT_W-1:0]              p2,
  output logic                          erro,
  output logic [2:0]                    state,
  output logic [$clog2(NDIG+1)-1:0]     idx
);

  localparam int IW = $clog2(NDIG + 1);
  localparam logic [IW-1:0] NDIG_W = IW'(NDIG);
  localparam logic [IW-1:0] LAST_W = IW'(NDIG - 1);
  localparam logic [IW-1:0] RUN2_W = IW'(RUN2);
  localparam logic [IW-1:0] ONE_W  = IW'(1);

  typedef enum logic [2:0] {
    S_COLL = 3'b000,
    S_DONE = 3'b001,
    S_SHOW = 3'b010,
    S_ERR  = 3'b011
  } state_t;

  state_t              state_q, state_n;
  logic [IW-1:0]       idx_q, idx_n;
  logic [IW-1:0]       cur_q, cur_n;
  logic [IW-1:0]       max_q, max_n;
  logic [1:0]          premio_q, premio_n;
  logic [CNT_W-1:0]    p1_q, p1_n;
  logic [CNT_W-1:0]    p2_q, p2_n;
  logic                erro_q, erro_n;
  logic [4*NDIG-1:0]   win_q, win_n;
  logic [3:0]          win_nib;
  logic [IW-1:0]       run_inc;
  logic                load_ok;

  // The first-entered digit lives in the most significant nibble.
  always_comb begin
    win_nib = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) win_nib = win_q[4*(NDIG-1-i) +: 4];
    end
  end

  assign run_inc = cur_q + ONE_W;
  assign load_ok = ((state_q == S_COLL) && (idx_q == '0)) ||
                   (state_q == S_SHOW) || (state_q == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_COLL;
      idx_q    <= '0;
      cur_q    <= '0;
      max_q    <= '0;
      premio_q <= 2'b00;
      p1_q     <= '0;
      p2_q     <= '0;
      erro_q   <= 1'b0;
      win_q    <= WIN_DEF;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      cur_q    <= cur_n;
      max_q    <= max_n;
      premio_q <= premio_n;
      p1_q     <= p1_n;
      p2_q     <= p2_n;
      erro_q   <= erro_n;
      win_q    <= win_n;
    end
  end

  // Only the highest-priority asserted strobe acts, even when it is ignored
  // in the current state.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    cur_n    = cur_q;
    max_n    = max_q;
    premio_n = premio_q;
    p1_n     = p1_q;
    p2_n     = p2_q;
    erro_n   = erro_q;
    win_n    = win_q;
    if (fim_jogo) begin
      state_n  = S_COLL;
      idx_n    = '0;
      cur_n    = '0;
      max_n    = '0;
      premio_n = 2'b00;
      erro_n   = 1'b0;
    end else if (carrega) begin
      if (load_ok) win_n = win_in;
    end else if (fim) begin
      if (state_q == S_DONE) begin
        state_n = S_SHOW;
        if (max_q == NDIG_W) begin
          premio_n = 2'b01;
          if (p1_q != '1) p1_n = p1_q + CNT_W'(1);
        end else if (max_q >= RUN2_W) begin
          premio_n = 2'b10;
          if (p2_q != '1) p2_n = p2_q + CNT_W'(1);
        end else begin
          premio_n = 2'b00;
        end
      end
    end else if (insere) begin
      if (state_q == S_COLL) begin
        if (num > 4'd9) begin
          state_n = S_ERR;
          erro_n  = 1'b1;
        end else begin
          idx_n = idx_q + ONE_W;
          if (num == win_nib) begin
            cur_n = run_inc;
            if (run_inc > max_q) max_n = run_inc;
          end else begin
            cur_n = '0;
          end
          if (idx_q == LAST_W) state_n = S_DONE;
        end
      end
    end
  end

  assign state  = state_q;
  assign idx    = idx_q;
  assign premio = premio_q;
  assign p1     = p1_q;
  assign p2     = p2_q;
  assign erro   = erro_q;

  // Structural invariants of the grading registers.
  a_no_premio_11 : assert property (@(posedge clk) disable iff (reset) premio_q != 2'b11);
  a_idx_bound    : assert property (@(posedge clk) disable iff (reset) idx_q <= NDIG_W);
  a_run_order    : assert property (@(posedge clk) disable iff (reset) cur_q <= max_q);
  a_max_bound    : assert property (@(posedge clk) disable iff (reset) max_q <= idx_q);

endmodule
